wb_regfile: RTL and testbench

Write-back stage and architectural register file for the five-stage MIPS pipeline. The block takes the MEM/WB latch outputs and selects the write-back value from load data, ALU result or link address. It commits that value to a 32×32 register file and serves the two combinational read ports used by the ID stage. It also exposes the selected write-back word for the forwarding unit, plus a retired-write counter and a sticky error flag for debug.

---
 rtl/wb_regfile.sv | 55 +++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back mux, 32x32 register file, commit counter and sticky error flag.
// Define WB_REGFILE_BYPASS_EN to forward the committing value to same-cycle reads.
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inLoadWordDividerMEM,
    input  logic [31:0] inAluLatch,
    input  logic [31:0] inPcPlus8,
    input  logic [4:0]  inMuxRtRd,
    input  logic        inRegWrite,
    input  logic [1:0]  inMemtoReg,
    input  logic [4:0]  inRs,
    input  logic [4:0]  inRt,
    output logic [31:0] outRsData,
    output logic [31:0] outRtData,
    output logic [31:0] outWriteData,
    output logic [31:0] outWbCount,
    output logic        outWbErr
);
    logic [31:0] regs [0:31];
    logic        commit;
    logic        bypassRs;
    logic        bypassRt;

    always_comb
        outWriteData = inMemtoReg == 2'b00 ? inAluLatch :
                       inMemtoReg == 2'b01 ? inLoadWordDividerMEM :
                       inMemtoReg == 2'b10 ? inPcPlus8 : '0;

    // Gated by rst_n so a held reset never leaks a pending write through the bypass.
    assign commit = rst_n && inRegWrite && inMuxRtRd != 5'd0 && inMemtoReg != 2'b11;

`ifdef WB_REGFILE_BYPASS_EN
    assign bypassRs = commit && inRs == inMuxRtRd;
    assign bypassRt = commit && inRt == inMuxRtRd;
`else
    assign bypassRs = 1'b0;
    assign bypassRt = 1'b0;
`endif

    assign outRsData = inRs == 5'd0 ? '0 : bypassRs ? outWriteData : regs[inRs];
    assign outRtData = inRt == 5'd0 ? '0 : bypassRt ? outWriteData : regs[inRt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            outWbCount <= '0;
            outWbErr   <= 1'b0;
        end else begin
            if (commit) regs[inMuxRtRd] <= outWriteData;
            if (commit) outWbCount <= outWbCount + 32'd1;
            if (inRegWrite && inMemtoReg == 2'b11) outWbErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Expectations follow WB_REGFILE_BYPASS_EN when it is defined for the build.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inLoadWordDividerMEM;
    logic [31:0] inAluLatch;
    logic [31:0] inPcPlus8;
    logic [4:0]  inMuxRtRd;
    logic        inRegWrite;
    logic [1:0]  inMemtoReg;
    logic [4:0]  inRs;
    logic [4:0]  inRt;
    logic [31:0] outRsData;
    logic [31:0] outRtData;
    logic [31:0] outWriteData;
    logic [31:0] outWbCount;
    logic        outWbErr;
    int          nChecks = 0;
    int          nFails = 0;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .inLoadWordDividerMEM(inLoadWordDividerMEM), .inAluLatch(inAluLatch), .inPcPlus8(inPcPlus8),
        .inMuxRtRd(inMuxRtRd), .inRegWrite(inRegWrite), .inMemtoReg(inMemtoReg),
        .inRs(inRs), .inRt(inRt),
        .outRsData(outRsData), .outRtData(outRtData), .outWriteData(outWriteData),
        .outWbCount(outWbCount), .outWbErr(outWbErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
        inRegWrite = we;
        inMuxRtRd = rd;
        inMemtoReg = sel;
        inAluLatch = alu;
        inLoadWordDividerMEM = ld;
        inPcPlus8 = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        inRs = 5'd0;
        inRt = 5'd0;
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 5'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            inRs = 5'(i);
            inRt = 5'(31 - i);
            #1;
            chk("reset_rs", outRsData, 32'h0);
            chk("reset_rt", outRtData, 32'h0);
        end
        chk("reset_count", outWbCount, 32'h0);
        chk("reset_err", {31'h0, outWbErr}, 32'h0);

        @(negedge clk);
        drive(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h1111_1111, 32'h2222_2222);
        #1 chk("wdata_alu", outWriteData, 32'h1234_5678);
        step();
        drive(1'b1, 5'd6, 2'b01, 32'h3333_3333, 32'hDEAD_BEEF, 32'h4444_4444);
        #1 chk("wdata_load", outWriteData, 32'hDEAD_BEEF);
        step();
        drive(1'b1, 5'd31, 2'b10, 32'h5555_5555, 32'h6666_6666, 32'h0040_0008);
        #1 chk("wdata_link", outWriteData, 32'h0040_0008);
        step();
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        inRs = 5'd5;
        inRt = 5'd6;
        #1;
        chk("rd_r5", outRsData, 32'h1234_5678);
        chk("rd_r6", outRtData, 32'hDEAD_BEEF);
        inRs = 5'd31;
        #1;
        chk("rd_r31", outRsData, 32'h0040_0008);
        chk("count_3", outWbCount, 32'd3);

        @(negedge clk);
        drive(1'b1, 5'd7, 2'b00, 32'h0000_0077, '0, '0);
        step();
        drive(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, '0, '0);
        step();
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        inRs = 5'd0;
        inRt = 5'd7;
        #1;
        chk("r0_zero", outRsData, 32'h0);
        chk("r7_pre", outRtData, 32'h0000_0077);
        chk("count_r0_dropped", outWbCount, 32'd4);
        @(negedge clk);
        drive(1'b1, 5'd7, 2'b11, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003);
        #1;
        chk("wdata_reserved", outWriteData, 32'h0);
        chk("err_before", {31'h0, outWbErr}, 32'h0);
        chk("r7_during", outRtData, 32'h0000_0077);
        step();
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        #1;
        chk("err_set", {31'h0, outWbErr}, 32'h1);
        chk("r7_unchanged", outRtData, 32'h0000_0077);
        chk("count_reserved", outWbCount, 32'd4);
        step();
        chk("err_sticky", {31'h0, outWbErr}, 32'h1);

        drive(1'b1, 5'd9, 2'b00, 32'h0000_0001, '0, '0);
        step();
        drive(1'b1, 5'd9, 2'b00, 32'hA5A5_A5A5, '0, '0);
        inRs = 5'd9;
        inRt = 5'd9;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("bypass_rs", outRsData, 32'hA5A5_A5A5);
        chk("bypass_rt", outRtData, 32'hA5A5_A5A5);
`else
        chk("bypass_rs", outRsData, 32'h0000_0001);
        chk("bypass_rt", outRtData, 32'h0000_0001);
`endif
        step();
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        #1;
        chk("after_rs", outRsData, 32'hA5A5_A5A5);
        chk("after_rt", outRtData, 32'hA5A5_A5A5);
        chk("count_6", outWbCount, 32'd6);

        force dut.outWbCount = 32'hFFFF_FFFE;
        #1;
        release dut.outWbCount;
        #1 chk("count_preload", outWbCount, 32'hFFFF_FFFE);
        drive(1'b1, 5'd10, 2'b00, 32'h0000_000A, '0, '0);
        step();
        #1 chk("count_max", outWbCount, 32'hFFFF_FFFF);
        drive(1'b1, 5'd11, 2'b01, '0, 32'h0000_000B, '0);
        step();
        #1 chk("count_wrap", outWbCount, 32'h0);
        inRs = 5'd10;
        inRt = 5'd11;
        #1;
        chk("r10", outRsData, 32'h0000_000A);
        chk("r11", outRtData, 32'h0000_000B);

        drive(1'b1, 5'd3, 2'b00, 32'h0000_0033, '0, '0);
        step();
        drive(1'b1, 5'd3, 2'b00, 32'hDEAD_0003, '0, '0);
        inRs = 5'd3;
        inRt = 5'd10;
        #1 chk("r3_pre", outRtData, 32'h0000_000A);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_r3", outRsData, 32'h0);
        chk("arst_r10", outRtData, 32'h0);
        chk("arst_count", outWbCount, 32'h0);
        chk("arst_err", {31'h0, outWbErr}, 32'h0);
        step();
        chk("arst_r3_edge", outRsData, 32'h0);
        chk("arst_count_edge", outWbCount, 32'h0);
        chk("arst_err_edge", {31'h0, outWbErr}, 32'h0);
        drive(1'b0, 5'd0, 2'b00, '0, '0, '0);
        rst_n = 1'b1;
        step();
        chk("post_r3", outRsData, 32'h0);
        chk("post_count", outWbCount, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
